bit_serial_subtractor: RTL and testbench
========================================

// Module: bit_serial_subtractor
// PURPOSE
//   Unsigned W-bit subtractor, diff = a - b, computed LSB-first at one bit per clock.
//   Each bit is built from two half-subtractor stages plus a registered borrow.
//   Complements the combinational adder cells in the arithmetic library.
//   Serves small-area datapaths; driven by a start/busy/done handshake.
// PARAMETERS
//   W     8    operand and result width in bits; legal range W >= 2
// PORTS
//   clk     in   1   single system clock; all state updates on the rising edge
//   rst_n   in   1   asynchronous, active-low reset
//   start   in   1   request; sampled only when the block is not busy
//   a       in   W   minuend; sampled on the accepted start edge
//   b       in   W   subtrahend; sampled on the accepted start edge
//   busy    out  1   high while bits are being processed
//   done    out  1   one-cycle pulse when diff/borrow become valid
//   diff    out  W   result; held stable from done until the next done
//   borrow  out  1   final borrow-out, high when a < b; held with diff
// BEHAVIOUR
//   - Reset: async assert of rst_n forces the following, regardless of clk:
//     - state = IDLE
//     - busy = 0, done = 0, diff = 0, borrow = 0
//     - internal shift registers, bit counter and borrow flop = 0
//   - FSM states and transitions:
//     - IDLE: start=1 latches a, b into shift regs; clears borrow flop and counter; goes to SHIFT.
//     - SHIFT: busy=1, one bit per cycle.
//       - x = a_sr[0] ^ b_sr[0]
//       - d = x ^ br
//       - br_next = (~a_sr[0] & b_sr[0]) | (~x & br)
//       - d shifts into the MSB of the result shift reg; a_sr and b_sr shift right.
//       - After W bit-cycles, goes to DONE.
//     - DONE: lasts one cycle.
//       - Registers diff <= result shift reg, borrow <= final br.
//       - done=1, busy=0.
//       - start=1 in this cycle is accepted exactly as in IDLE (back-to-back ops); otherwise goes to IDLE.
//   - Latency:
//     - start accepted at edge 0 -> busy high during cycles 1..W.
//     - done pulse in cycle W+1.
//     - Throughput: one op per W+1 cycles.
//   - start while in SHIFT is ignored; a and b may change freely while busy.
//   - diff and borrow change only on the DONE cycle; they never show partial results.
//   - Bit counter width: $clog2(W)+1. Wrap-around is impossible because the counter clears on accept.
//   - Reset mid-operation aborts immediately; the next start after reset release behaves normally.
//   - All arithmetic is modulo 2^W: diff = (a - b) mod 2^W, borrow = (a < b).
// CONFIGURATION
//   SUB_SATURATE_EN
//     - Defined: when the final borrow is 1, diff is registered as 0 (clamp at zero).
//       borrow still reports 1; timing is unchanged.
//     - Undefined: diff is the wrapped modulo-2^W result; no clamp logic is generated.
// TESTING
//   1. W=8, a=100, b=37, start pulse -> done in cycle 9, diff=63, borrow=0; busy high cycles 1..8.
//   2. a=5, b=9 -> diff=8'hFC, borrow=1.
//      With SUB_SATURATE_EN: diff=8'h00, borrow=1.
//   3. a=8'hA5, b=8'hA5 -> diff=0, borrow=0.
//      Then a=0, b=255 -> diff=1, borrow=1 (diff=0 with SUB_SATURATE_EN).
//   4. start=1 held continuously with a=200, b=50, and a,b changed while busy ->
//      first result diff=150; a second op starts in the DONE cycle; its done follows 9 cycles later.
//   5. start pulses while busy -> ignored; exactly one done per accepted start; diff unchanged until done.
//   6. rst_n low in cycle 4 of an op -> all outputs 0 asynchronously, no done;
//      after release, a=10, b=3 -> diff=7, borrow=0.

Source files
------------

// File: rtl/bit_serial_subtractor.sv
// Unsigned W-bit serial subtractor, LSB first, one bit per clock; done pulse W+1 cycles after accepted start.
// start is ignored while busy; a start in the DONE cycle is accepted back-to-back. Define SUB_SATURATE_EN to clamp negative results to zero.
module bit_serial_subtractor #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         borrow
);

  localparam int CW = $clog2(W) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_sr_q, a_sr_d;
  logic [W-1:0]    b_sr_q, b_sr_d;
  logic [W-1:0]    res_q, res_d;
  logic            br_q, br_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    diff_q, diff_d;
  logic            borrow_q, borrow_d;

  // Two half-subtractor stages: a-b, then minus the registered borrow.
  logic            x_bit, d_bit, br_nxt;
  logic [W-1:0]    res_shift;
  logic [W-1:0]    final_diff;

  always_comb begin
    x_bit     = a_sr_q[0] ^ b_sr_q[0];
    d_bit     = x_bit ^ br_q;
    br_nxt    = (~a_sr_q[0] & b_sr_q[0]) | (~x_bit & br_q);
    res_shift = {d_bit, res_q[W-1:1]};
`ifdef SUB_SATURATE_EN
    final_diff = br_nxt ? '0 : res_shift;
`else
    final_diff = res_shift;
`endif
  end

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        res_d  = res_shift;
        br_d   = br_nxt;
        cnt_d  = cnt_q + CW'(1);
        // Results land on the edge entering DONE so they are valid alongside the done pulse.
        if (cnt_q == CW'(W - 1)) begin
          diff_d   = final_diff;
          borrow_d = br_nxt;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy   = (state_q == SHIFT);
  assign done   = (state_q == DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed bench for bit_serial_subtractor (W=8): latency, wrap/borrow, back-to-back, ignored starts, async reset.
module tb_bit_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow;
  logic [W-1:0] diff;

  int n_assert = 0;
  int n_fail   = 0;

  bit_serial_subtractor #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .borrow(borrow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Accept one op, wait (bounded) for done, check latency and result, then return to IDLE.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] exp_d, input logic exp_b);
    int cyc;
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 20) begin
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, cyc, W + 1);
    chk({tag, "_diff"}, diff, exp_d);
    chk({tag, "_borrow"}, borrow, exp_b);
    tick();
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  logic [W-1:0] sat_5_9, sat_0_255;
  int ndone;

  initial begin
`ifdef SUB_SATURATE_EN
    sat_5_9 = 8'h00; sat_0_255 = 8'h00;
`else
    sat_5_9 = 8'hFC; sat_0_255 = 8'h01;
`endif
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_borrow", borrow, 0);
    tick(2);
    rst_n = 1'b1;
    tick();

    // 1: cycle-accurate latency for 100-37
    a = 8'd100; b = 8'd37; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_busy_c1", busy, 1);
    chk("t1_done_c1", done, 0);
    tick(7);
    chk("t1_busy_c8", busy, 1);
    chk("t1_done_c8", done, 0);
    chk("t1_diff_hold", diff, 0);
    tick();
    chk("t1_done_c9", done, 1);
    chk("t1_busy_c9", busy, 0);
    chk("t1_diff", diff, 63);
    chk("t1_borrow", borrow, 0);
    tick();
    chk("t1_idle_done", done, 0);
    chk("t1_diff_kept", diff, 63);

    // 2, 3: wrap/borrow and equality
    run_op("t2", 8'd5, 8'd9, sat_5_9, 1'b1);
    run_op("t3a", 8'hA5, 8'hA5, 8'h00, 1'b0);
    run_op("t3b", 8'd0, 8'd255, sat_0_255, 1'b1);

    // 4: start held high, operands changed while busy, back-to-back accept in DONE
    a = 8'd200; b = 8'd50; start = 1'b1;
    tick();
    a = 8'd1; b = 8'd2;
    tick(7);
    chk("t4_busy_before", busy, 1);
    a = 8'd30; b = 8'd10;
    tick();
    chk("t4_done1", done, 1);
    chk("t4_diff1", diff, 150);
    tick();
    chk("t4_busy_again", busy, 1);
    chk("t4_done_gone", done, 0);
    chk("t4_diff1_held", diff, 150);
    start = 1'b0;
    a = 8'd0; b = 8'd0;
    tick(7);
    chk("t4_no_early_done", done, 0);
    tick();
    chk("t4_done2", done, 1);
    chk("t4_diff2", diff, 20);
    tick();

    // 5: start pulses while busy are ignored
    a = 8'd50; b = 8'd20; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int i = 1; i <= 14; i++) begin
      if (i == 2 || i == 4 || i == 5) begin
        start = 1'b1; a = 8'd1; b = 8'd200;
      end else begin
        start = 1'b0;
      end
      if (i == 4) chk("t5_diff_unchanged", diff, 20);
      tick();
      if (done) ndone++;
    end
    start = 1'b0;
    chk("t5_one_done", ndone, 1);
    chk("t5_diff", diff, 30);
    chk("t5_borrow", borrow, 0);

    // 6: async reset mid-operation
    a = 8'd100; b = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_diff", diff, 0);
    chk("t6_rst_borrow", borrow, 0);
    ndone = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) ndone++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("t6_no_done", ndone, 0);
    run_op("t6_after", 8'd10, 8'd3, 8'd7, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
